// File: rtl/uart_rx_param.sv
// Parametrised UART receiver.
// Features: an input synchroniser, rejection of glitches on the start bit,
// configurable data width, parity and stop-bit count, and reporting of
// parity, framing and break conditions.
// A new frame's payload and error flags are presented together with a
// one-cycle complete pulse, and they hold until the next frame finishes.
module uart_rx_param #(
  parameter int CLOCK_SPEED = 12000000,
  parameter int BAUD_RATE   = 115200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] dataOut,
  output logic                 complete,
  output logic                 parityError,
  output logic                 frameError,
  output logic                 breakDetect
);

  localparam int CLOCK_DELAY = CLOCK_SPEED / BAUD_RATE;
  localparam int HALF        = CLOCK_DELAY / 2;
  localparam int CW          = $clog2(CLOCK_DELAY + 1);
  localparam int BW          = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(CLOCK_DELAY - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(HALF - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } state_t;

  // Returns 1 when the received parity bit disagrees with the configured mode.
  function automatic logic parity_error(input logic [DATA_BITS-1:0] d, input logic p);
    logic x;
    x = (^d) ^ p;
    parity_error = (PARITY == 32'sd2) ? x : ((PARITY == 32'sd1) ? ~x : 1'b0);
  endfunction

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   rxs_s;

  state_t                 state_r, state_s;
  logic [CW-1:0]          cnt_r, cnt_s;
  logic [BW-1:0]          bit_r, bit_s;
  logic [DATA_BITS-1:0]   shift_r, shift_s;
  logic                   par_bit_r, par_bit_s;
  logic                   ferr_r, ferr_s;
  logic                   first_stop_r, first_stop_s;
  logic [DATA_BITS-1:0]   data_r, data_s;
  logic                   complete_r, complete_s;
  logic                   perr_r, perr_s;
  logic                   fout_r, fout_s;
  logic                   brk_r, brk_s;
  logic                   ferr_now_s;

  // Metastability synchroniser on the raw serial line; idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {SYNC_STAGES{1'b1}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], uart_rx};
    end
  end

  assign rxs_s = sync_r[SYNC_STAGES-1];

  // State register together with the frame datapath and the output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      cnt_r        <= {CW{1'b0}};
      bit_r        <= {BW{1'b0}};
      shift_r      <= {DATA_BITS{1'b0}};
      par_bit_r    <= 1'b0;
      ferr_r       <= 1'b0;
      first_stop_r <= 1'b0;
      data_r       <= {DATA_BITS{1'b0}};
      complete_r   <= 1'b0;
      perr_r       <= 1'b0;
      fout_r       <= 1'b0;
      brk_r        <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      bit_r        <= bit_s;
      shift_r      <= shift_s;
      par_bit_r    <= par_bit_s;
      ferr_r       <= ferr_s;
      first_stop_r <= first_stop_s;
      data_r       <= data_s;
      complete_r   <= complete_s;
      perr_r       <= perr_s;
      fout_r       <= fout_s;
      brk_r        <= brk_s;
    end
  end

  // Next-state logic: bit timing, sampling, and assembling the frame result.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    bit_s        = bit_r;
    shift_s      = shift_r;
    par_bit_s    = par_bit_r;
    ferr_s       = ferr_r;
    first_stop_s = first_stop_r;
    data_s       = data_r;
    complete_s   = 1'b0;
    perr_s       = perr_r;
    fout_s       = fout_r;
    brk_s        = brk_r;
    ferr_now_s   = ferr_r | ~rxs_s;

    case (state_r)
      S_IDLE: begin
        cnt_s = {CW{1'b0}};
        bit_s = {BW{1'b0}};
        if (!rxs_s) begin
          state_s = S_START;
        end else begin
          state_s = S_IDLE;
        end
      end

      S_START: begin
        if (rxs_s) begin
          // The line went high before mid-start: treat it as a glitch.
          state_s = S_IDLE;
          cnt_s   = {CW{1'b0}};
        end else if (cnt_r == CNT_HALF) begin
          state_s   = S_DATA;
          cnt_s     = {CW{1'b0}};
          bit_s     = {BW{1'b0}};
          ferr_s    = 1'b0;
          par_bit_s = 1'b0;
        end else begin
          cnt_s = cnt_r + CW'(1'b1);
        end
      end

      S_DATA: begin
        if (cnt_r == CNT_LAST) begin
          cnt_s   = {CW{1'b0}};
          // Shift in from the top so that the first bit received lands at bit 0.
          shift_s = {rxs_s, shift_r[DATA_BITS-1:1]};
          if (bit_r == DATA_LAST) begin
            bit_s = {BW{1'b0}};
            if (PARITY != 32'sd0) begin
              state_s = S_PARITY;
            end else begin
              state_s = S_STOP;
            end
          end else begin
            bit_s = bit_r + BW'(1'b1);
          end
        end else begin
          cnt_s = cnt_r + CW'(1'b1);
        end
      end

      S_PARITY: begin
        if (cnt_r == CNT_LAST) begin
          cnt_s     = {CW{1'b0}};
          par_bit_s = rxs_s;
          state_s   = S_STOP;
        end else begin
          cnt_s = cnt_r + CW'(1'b1);
        end
      end

      S_STOP: begin
        if (cnt_r == CNT_LAST) begin
          cnt_s  = {CW{1'b0}};
          ferr_s = ferr_now_s;
          if (bit_r == {BW{1'b0}}) begin
            first_stop_s = rxs_s;
          end else begin
            first_stop_s = first_stop_r;
          end
          if (bit_r == STOP_LAST) begin
            bit_s      = {BW{1'b0}};
            complete_s = 1'b1;
            data_s     = shift_r;
            perr_s     = parity_error(shift_r, par_bit_r);
            fout_s     = ferr_now_s;
            brk_s      = (shift_r == {DATA_BITS{1'b0}}) &&
                         ((PARITY == 32'sd0) || !par_bit_r) &&
                         ((bit_r == {BW{1'b0}}) ? !rxs_s : !first_stop_r);
            // A low stop bit must not be mistaken for the next start bit.
            if (ferr_now_s) begin
              state_s = S_WAIT_HIGH;
            end else begin
              state_s = S_IDLE;
            end
          end else begin
            bit_s = bit_r + BW'(1'b1);
          end
        end else begin
          cnt_s = cnt_r + CW'(1'b1);
        end
      end

      S_WAIT_HIGH: begin
        cnt_s = {CW{1'b0}};
        if (rxs_s) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_WAIT_HIGH;
        end
      end

      default: begin
        state_s = S_IDLE;
        cnt_s   = {CW{1'b0}};
        bit_s   = {BW{1'b0}};
      end
    endcase
  end

  assign dataOut     = data_r;
  assign complete    = complete_r;
  assign parityError = perr_r;
  assign frameError  = fout_r;
  assign breakDetect = brk_r;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three instances (8N1, 8E1, 5N2) are driven with
// directed frames. A frame-level model predicts the cycle of each complete
// pulse and the decoded fields, and these predictions are compared with the
// DUTs on every cycle.
module tb_uart_rx_param;

  localparam int CD   = 16;
  localparam int HALF = 8;
  localparam int SYNC = 2;

  typedef struct {
    int         id;
    int         cyc;
    logic [8:0] d;
    logic       pe;
    logic       fe;
    logic       brk;
  } ev_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] line  = 3'b111;
  logic [7:0] dout_a, dout_b;
  logic [4:0] dout_c;
  logic [2:0] comp, pe, fe, brk;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   ncomp[3];
  ev_t  q[$];
  logic [8:0] hd[3];
  logic hpe[3], hfe[3], hbrk[3];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_param #(.CLOCK_SPEED(1600000), .BAUD_RATE(100000), .DATA_BITS(8),
                  .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .uart_rx(line[0]), .dataOut(dout_a),
    .complete(comp[0]), .parityError(pe[0]), .frameError(fe[0]), .breakDetect(brk[0]));

  uart_rx_param #(.CLOCK_SPEED(1600000), .BAUD_RATE(100000), .DATA_BITS(8),
                  .PARITY(2), .STOP_BITS(1), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .uart_rx(line[1]), .dataOut(dout_b),
    .complete(comp[1]), .parityError(pe[1]), .frameError(fe[1]), .breakDetect(brk[1]));

  uart_rx_param #(.CLOCK_SPEED(1600000), .BAUD_RATE(100000), .DATA_BITS(5),
                  .PARITY(0), .STOP_BITS(2), .SYNC_STAGES(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .uart_rx(line[2]), .dataOut(dout_c),
    .complete(comp[2]), .parityError(pe[2]), .frameError(fe[2]), .breakDetect(brk[2]));

  function automatic int db_of(input int id);
    return (id == 2) ? 5 : 8;
  endfunction

  function automatic int par_of(input int id);
    return (id == 1) ? 2 : 0;
  endfunction

  function automatic int sb_of(input int id);
    return (id == 2) ? 2 : 1;
  endfunction

  function automatic int nper_of(input int id);
    return 1 + db_of(id) + ((par_of(id) != 0) ? 1 : 0) + sb_of(id);
  endfunction

  function automatic logic [8:0] dout_of(input int id);
    case (id)
      0:       return {1'b0, dout_a};
      1:       return {1'b0, dout_b};
      default: return {4'b0000, dout_c};
    endcase
  endfunction

  // Line levels for one bit period each, LSB first: start, data, [parity], stops.
  function automatic logic [31:0] mk(input int id, input logic [8:0] d, input logic pb,
                                     input logic [1:0] st);
    logic [31:0] v;
    int p;
    v = 32'hFFFF_FFFF;
    v[0] = 1'b0;
    for (int i = 0; i < db_of(id); i++) v[1+i] = d[i];
    p = 1 + db_of(id);
    if (par_of(id) != 0) begin
      v[p] = pb;
      p = p + 1;
    end
    for (int j = 0; j < sb_of(id); j++) v[p+j] = st[j];
    return v;
  endfunction

  // Frame-level decode of a level sequence that starts after cycle k.
  function automatic ev_t model(input int id, input logic [31:0] lv, input int k);
    ev_t e;
    int db, p, ones;
    logic pb;
    db = db_of(id);
    e.id = id;
    e.d = 9'h000;
    for (int i = 0; i < db; i++) e.d[i] = lv[1+i];
    p = 1 + db;
    pb = 1'b0;
    if (par_of(id) != 0) begin
      pb = lv[p];
      p = p + 1;
    end
    ones = $countones(e.d) + int'(pb);
    if (par_of(id) == 1) e.pe = ((ones % 2) == 0);
    else if (par_of(id) == 2) e.pe = ((ones % 2) == 1);
    else e.pe = 1'b0;
    e.fe = 1'b0;
    for (int j = 0; j < sb_of(id); j++) if (lv[p+j] == 1'b0) e.fe = 1'b1;
    e.brk = (e.d == 9'h000) && !pb && !lv[p];
    e.cyc = k + SYNC + 1 + HALF + CD * (nper_of(id) - 1);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one bit period per level; called and returns #1 after a rising edge.
  task automatic run_frame(input int id, input logic [31:0] lv, input int nper, input bit want);
    if (want) q.push_back(model(id, lv, cyc));
    for (int i = 0; i < nper; i++) begin
      line[id] = lv[i];
      repeat (CD) @(posedge clk);
      #1;
    end
  endtask

  // Per-cycle comparison of every DUT against the model.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        bit ec;
        ec = 1'b0;
        if (!rst_n) begin
          hd[i] = 9'h000; hpe[i] = 1'b0; hfe[i] = 1'b0; hbrk[i] = 1'b0;
          for (int j = q.size() - 1; j >= 0; j--) if (q[j].id == i) q.delete(j);
        end else begin
          for (int j = 0; j < q.size(); j++) begin
            if (q[j].id == i) begin
              if (q[j].cyc == cyc) begin
                ec = 1'b1;
                hd[i] = q[j].d; hpe[i] = q[j].pe; hfe[i] = q[j].fe; hbrk[i] = q[j].brk;
                q.delete(j);
              end
              break;
            end
          end
        end
        if (comp[i]) ncomp[i]++;
        chk($sformatf("complete_%0d", i), 32'(comp[i]), 32'(ec));
        chk($sformatf("outputs_%0d", i), 32'({dout_of(i), pe[i], fe[i], brk[i]}),
            32'({hd[i], hpe[i], hfe[i], hbrk[i]}));
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      ncomp[i] = 0; hd[i] = 9'h000; hpe[i] = 1'b0; hfe[i] = 1'b0; hbrk[i] = 1'b0;
    end
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 32'({dout_a, dout_b, dout_c, comp, pe, fe, brk}), 32'h0);
    rst_n = 1'b1;
    idle(20);

    // 8N1 back-to-back frames
    run_frame(0, mk(0, 9'h0A5, 1'b0, 2'b11), nper_of(0), 1'b1);
    run_frame(0, mk(0, 9'h05A, 1'b0, 2'b11), nper_of(0), 1'b1);
    idle(10);
    chk("a_b2b_count", 32'(ncomp[0]), 32'd2);
    chk("a_b2b_data", 32'(dout_a), 32'h5A);
    chk("a_b2b_flags", 32'({pe[0], fe[0], brk[0]}), 32'h0);

    // even parity, wrong then right parity bit
    run_frame(1, mk(1, 9'h003, 1'b1, 2'b11), nper_of(1), 1'b1);
    idle(10);
    chk("b_bad_parity", 32'({dout_b, pe[1], fe[1]}), 32'({8'h03, 1'b1, 1'b0}));
    run_frame(1, mk(1, 9'h003, 1'b0, 2'b11), nper_of(1), 1'b1);
    idle(10);
    chk("b_good_parity", 32'({dout_b, pe[1], fe[1]}), 32'({8'h03, 1'b0, 1'b0}));

    // low stop bit, then recovery
    run_frame(0, mk(0, 9'h055, 1'b0, 2'b10), nper_of(0), 1'b1);
    line[0] = 1'b1;
    idle(40);
    chk("a_stop_low", 32'({dout_a, fe[0], brk[0]}), 32'({8'h55, 1'b1, 1'b0}));
    run_frame(0, mk(0, 9'h00F, 1'b0, 2'b11), nper_of(0), 1'b1);
    idle(10);
    chk("a_after_ferr", 32'({dout_a, fe[0]}), 32'({8'h0F, 1'b0}));

    // 5-cycle glitch must be ignored
    line[0] = 1'b0;
    idle(5);
    line[0] = 1'b1;
    idle(40);
    chk("a_glitch_count", 32'(ncomp[0]), 32'd4);
    run_frame(0, mk(0, 9'h0C3, 1'b0, 2'b11), nper_of(0), 1'b1);
    idle(10);
    chk("a_after_glitch", 32'(dout_a), 32'hC3);

    // 20-bit-time break
    run_frame(0, 32'h0, 20, 1'b1);
    line[0] = 1'b1;
    idle(100);
    chk("a_break_count", 32'(ncomp[0]), 32'd6);
    chk("a_break_flags", 32'({dout_a, fe[0], brk[0]}), 32'({8'h00, 1'b1, 1'b1}));
    run_frame(0, mk(0, 9'h03C, 1'b0, 2'b11), nper_of(0), 1'b1);
    idle(10);
    chk("a_after_break", 32'({dout_a, fe[0], brk[0]}), 32'({8'h3C, 1'b0, 1'b0}));
    chk("a_final_count", 32'(ncomp[0]), 32'd7);

    // 5 data bits, 2 stop bits
    run_frame(2, mk(2, 9'h015, 1'b0, 2'b11), nper_of(2), 1'b1);
    idle(10);
    chk("c_5n2_data", 32'({dout_c, fe[2]}), 32'({5'h15, 1'b0}));

    // reset during data bit 3 discards the frame
    fork
      run_frame(2, mk(2, 9'h01B, 1'b0, 2'b11), nper_of(2), 1'b0);
      begin
        repeat (70) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("c_in_reset", 32'({dout_c, comp[2], fe[2], brk[2]}), 32'h0);
        rst_n = 1'b1;
      end
    join
    idle(20);
    chk("c_reset_count", 32'(ncomp[2]), 32'd1);
    chk("c_reset_outputs", 32'({dout_c, dout_a}), 32'h0);
    run_frame(2, mk(2, 9'h00A, 1'b0, 2'b11), nper_of(2), 1'b1);
    idle(10);
    chk("c_after_reset", 32'(dout_c), 32'h0A);
    chk("c_final_count", 32'(ncomp[2]), 32'd2);

    idle(50);
    chk("model_queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
